int_timer: RTL

//   Memory-mapped countdown timer; the interrupt source at the other end of the CP0

---
 rtl/int_timer.sv | 119 +++++++++++
 1 files changed

// File: rtl/int_timer.sv
// Memory-mapped countdown timer that drives one CP0 HWInt line.
// Software programs CTRL and PRESET over the bus; the timer counts PRESET down
// to zero and raises irq_flag. irq reaches CP0 only while CTRL.IM is set.
//
// state | meaning
// IDLE  | waiting for CTRL.EN; COUNT holds
// LOAD  | copy PRESET into COUNT
// CNT   | decrement COUNT toward zero
// INT   | expiry: one-shot clears EN, auto-reload drops the pulse and restarts
module int_timer #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_flag;

    logic wr_ctrl;
    logic wr_preset;
    logic force_idle;
    logic en;
    logic auto_reload;

    assign wr_ctrl     = we && (addr == 2'd0);
    assign wr_preset   = we && (addr == 2'd1);
    // A software write to CTRL or PRESET restarts the timer and acknowledges
    // any pending request, overriding whatever the FSM would do this cycle.
    assign force_idle  = wr_ctrl || wr_preset;
    assign en          = ctrl[0];
    // Only MODE==1 reloads; the two unused encodings fall back to one-shot.
    assign auto_reload = (ctrl[2:1] == 2'b01);

    // Register file writes, FSM sequencing and the down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= din[3:0];
            end
            if (wr_preset) begin
                preset <= din[CNT_W-1:0];
            end

            if (force_idle) begin
                state    <= IDLE;
                irq_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        count <= preset;
                        state <= CNT;
                    end
                    CNT: begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (count > CNT_W'(1)) begin
                            count <= count - CNT_W'(1);
                        end else begin
                            // Covers PRESET=0 as well, so COUNT never wraps.
                            count    <= '0;
                            irq_flag <= 1'b1;
                            state    <= INT;
                        end
                    end
                    INT: begin
                        if (auto_reload) begin
                            irq_flag <= 1'b0;
                        end else begin
                            ctrl[0] <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Combinational read mux; unused bits and the spare address read as zero.
    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout[3:0]       = ctrl;
            2'd1:    dout[CNT_W-1:0] = preset;
            2'd2:    dout[CNT_W-1:0] = count;
            default: dout            = 32'd0;
        endcase
    end

    assign irq = ctrl[3] & irq_flag;

endmodule
